// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard signals; perf counter outputs exist only with HAZ_PERF_CNT_EN.
interface hazard_ctrl_if;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] LoadUseCnt, MemStallCnt, FlushCnt;
  modport master(
    input Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr,
    output LoadUseCnt, MemStallCnt, FlushCnt
  );
  modport slave(
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    input ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr,
    input LoadUseCnt, MemStallCnt, FlushCnt
  );
`else
  modport master(
    input Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr
  );
  modport slave(
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    input ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/branch hazards and memory wait-state FSM for the 5-stage core.
// Optional saturating perf counters under HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  hazard_ctrl_if.master h
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic mem_err, mem_stall, lw_stall, timeout;
  logic [1:0] fwd_a, fwd_b;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mem_err <= mem_err | timeout;
    end
  // WAIT exits on ready, on a dropped request, or when the timeout is reached
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mem_stall = 1'b0;
    timeout = 1'b0;
    if (state == IDLE) begin
      if (h.MemReqM && !h.MemReadyM) begin
        mem_stall = 1'b1;
        state_n = WAIT;
        cnt_n = 8'd1;
      end
    end else if (h.MemReadyM || !h.MemReqM) begin
      state_n = IDLE;
      cnt_n = 8'd0;
    end else if (cnt < TMO) begin
      mem_stall = 1'b1;
      cnt_n = cnt + 8'd1;
    end else begin
      timeout = 1'b1;
      state_n = IDLE;
      cnt_n = 8'd0;
    end
  end
  always_comb begin
    fwd_a = (h.RegWriteM && h.RdM != 5'd0 && h.RdM == h.Rs1E) ? 2'b10 :
            (h.RegWriteW && h.RdW != 5'd0 && h.RdW == h.Rs1E) ? 2'b01 : 2'b00;
    fwd_b = (h.RegWriteM && h.RdM != 5'd0 && h.RdM == h.Rs2E) ? 2'b10 :
            (h.RegWriteW && h.RdW != 5'd0 && h.RdW == h.Rs2E) ? 2'b01 : 2'b00;
    lw_stall = h.ResultSrcE0 && h.RdE != 5'd0 && (h.Rs1D == h.RdE || h.Rs2D == h.RdE);
  end
  // every output is held low while reset is asserted
  always_comb begin
    h.ForwardAE = reset ? 2'b00 : fwd_a;
    h.ForwardBE = reset ? 2'b00 : fwd_b;
    h.StallF = !reset && (lw_stall || mem_stall);
    h.StallD = !reset && (lw_stall || mem_stall);
    h.StallE = !reset && mem_stall;
    h.StallM = !reset && mem_stall;
    h.FlushW = !reset && mem_stall;
    h.FlushD = !reset && h.PCSrcE && !mem_stall;
    h.FlushE = !reset && (lw_stall || h.PCSrcE) && !mem_stall;
    h.MemErr = !reset && mem_err;
  end
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] lu_cnt, ms_cnt, fl_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lu_cnt <= 32'd0;
      ms_cnt <= 32'd0;
      fl_cnt <= 32'd0;
    end else begin
      lu_cnt <= lu_cnt + {31'd0, lw_stall && !mem_stall && lu_cnt != '1};
      ms_cnt <= ms_cnt + {31'd0, mem_stall && ms_cnt != '1};
      fl_cnt <= fl_cnt + {31'd0, h.PCSrcE && !mem_stall && fl_cnt != '1};
    end
  always_comb begin
    h.LoadUseCnt = lu_cnt;
    h.MemStallCnt = ms_cnt;
    h.FlushCnt = fl_cnt;
  end
`endif
endmodule
